lsu: RTL and testbench
======================

# lsu

Load/store unit: initiator side of the data-memory interface. Accepts one load or store at a time from the execute stage and checks RISC-V funct3 mode and alignment. Drives a word-aligned, byte-enabled, big-endian memory port with a req/ack handshake that tolerates wait states. Returns sign/zero-extended load data or store completion to writeback.

## Interface
Parameters:
- ACK_TIMEOUT, default 255: maximum cycles to wait for mem_ack before aborting with an error. 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept a request
- req_is_write  in  1  1 = store, 0 = load
- req_mode  in  3  funct3: B=000, H=001, W=010, BU=100, HU=101
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  writeback accepts response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal mode, or timeout
- mem_req  out  1  memory access in progress
- mem_we  out  1  write strobe
- mem_addr  out  32  word address, bits [1:0] always 0
- mem_be  out  4  byte enables; be[3] = byte offset 0 = bits [31:24]
- mem_wdata  out  32  lane-placed store data
- mem_ack  in  1  memory completes access this cycle
- mem_rdata  in  32  read word, valid when mem_ack=1

## Operation
- States:
  - IDLE: req_ready=1. On req_valid, capture the request.
    - Legal and aligned: go to BUS.
    - Otherwise: go to RESP with rsp_err=1. No memory access is made.
  - BUS: mem_req=1, all mem_* outputs stable until mem_ack=1.
    - On ack: capture load data, go to RESP with err=0.
    - On timeout: go to RESP with err=1, rdata=0.
  - RESP: rsp_valid=1, outputs stable until rsp_ready=1, then go to IDLE.
- Illegal cases:
  - req_mode 011, 110 or 111 is illegal.
  - A store with BU or HU mode is illegal.
  - H/HU with addr[0]=1 is misaligned.
  - W with addr[1:0]≠0 is misaligned.
- Byte order is big-endian. Offset o = addr[1:0] selects lane bits [31-8o -: 8]. Half at offset 0 is bits [31:16]; at offset 2 it is bits [15:0].
- Stores:
  - B: be = one-hot of lane o; wdata = byte replicated ×4.
  - H: be = 1100 or 0011; wdata = half replicated ×2.
  - W: be = 1111.
- Loads: mem_be is set as for a store of the same width; mem_wdata=0.
  - B/H: sign-extend from the selected lane.
  - BU/HU: zero-extend.
  - W: pass the word through unchanged.
- Timeout counter: clears on entry to BUS and increments each BUS cycle without ack. Timeout fires when the count equals ACK_TIMEOUT. If mem_ack=1 arrives in the same cycle the timeout fires, the ack wins.

## Timing
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; mem_req=0; mem_we=0; mem_addr=0; mem_be=0; mem_wdata=0.
- Request accepted at edge N:
  - mem_req is high in cycle N+1.
  - With ack in N+1 (zero wait), rsp_valid is high in cycle N+2.
  - Each wait state adds one cycle.
- An error detected at accept gives rsp_valid in N+1.
- RESP→IDLE on the rsp_ready edge. The next request is accepted no earlier than the following edge, so there is no back-to-back overlap. Throughput is at most 1 access per 3 cycles.
- All outputs are registered. mem_rdata is sampled only on the edge where mem_ack=1.
- Reset asserted mid-BUS drops mem_req immediately (asynchronous) and discards the transaction. No response is produced.

## Structure
- Package lsu_pkg holds:
  - the FUNCT3_B/H/W/BU/HU constants (shared with the memory model and decoder);
  - the state enum {IDLE, BUS, RESP};
  - the lane-index function.
- One combinational sub-module, lsu_align, contains:
  - request legality and alignment check;
  - be/wdata generation;
  - load lane select and extension.
- The top level holds only the FSM, capture registers and timeout counter.

## Test plan
- LB addr 0x103, mem_rdata 0x112233F0, zero wait → mem_addr 0x100, be 0001; rsp_rdata 0xFFFFFFF0, err=0, rsp_valid 2 cycles after accept.
- SH addr 0x102, wdata 0x0000BEEF, ack after 3 wait states → mem_we=1, be 0011, wdata 0xBEEFBEEF held stable 4 cycles; rsp err=0, rdata=0.
- LHU addr 0x101 → rsp_err=1 one cycle after accept; mem_req never asserted. Repeat with SB mode=BU and with mode=111 → err=1.
- LW addr 0x200 with ACK_TIMEOUT=4 and mem_ack tied low → mem_req high for exactly 4 cycles, then rsp err=1, rdata=0. Repeat with ack arriving in cycle 4 → err=0, data captured.
- LW returned with rsp_ready held low for 5 cycles → rsp_valid, rsp_rdata and rsp_err stable, req_ready=0 throughout; new request accepted only after the handshake.
- rst_n pulsed low during BUS → mem_req falls without waiting for a clock edge, all outputs at reset values, no response emitted; next LBU addr 0x0 completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the big-endian lane position helper.
package lsu_pkg;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Bit index of the least significant bit of byte lane 'off' in a
  // big-endian word: offset 0 lives in [31:24], offset 3 in [7:0].
  function automatic logic [4:0] lane_lsb(input logic [1:0] off);
    return {~off, 3'b000};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational request checker, byte-lane steering for the memory port and
// load data extraction/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_write,
  input  logic [2:0]  mode,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic        legal,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  input  logic [2:0]  ld_mode,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic mode_ok;
  logic aligned;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Legality: unsigned modes are load-only, halves need even, words need
  // word-aligned addresses.
  always_comb begin
    mode_ok = 1'b0;
    aligned = 1'b0;
    case (mode)
      FUNCT3_B:  begin mode_ok = 1'b1;      aligned = 1'b1;         end
      FUNCT3_BU: begin mode_ok = !is_write; aligned = 1'b1;         end
      FUNCT3_H:  begin mode_ok = 1'b1;      aligned = !off[0];      end
      FUNCT3_HU: begin mode_ok = !is_write; aligned = !off[0];      end
      FUNCT3_W:  begin mode_ok = 1'b1;      aligned = (off == 2'b00); end
      default:   begin mode_ok = 1'b0;      aligned = 1'b0;         end
    endcase
    legal = mode_ok && aligned;
  end

  // Byte enables and replicated store data; loads use the same enables.
  always_comb begin
    case (mode[1:0])
      2'b00: begin
        be         = 4'b1000 >> off;
        lane_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        be         = off[1] ? 4'b0011 : 4'b1100;
        lane_wdata = {2{wdata[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        lane_wdata = wdata;
      end
    endcase
  end

  // Pick the addressed lane out of the read word and extend it.
  always_comb begin
    byte_v = rdata[lane_lsb(ld_off) +: 8];
    half_v = rdata[lane_lsb(ld_off | 2'b01) +: 16];
    case (ld_mode)
      FUNCT3_B:  ld_data = {{24{byte_v[7]}}, byte_v};
      FUNCT3_BU: ld_data = {24'd0, byte_v};
      FUNCT3_H:  ld_data = {{16{half_v[15]}}, half_v};
      FUNCT3_HU: ld_data = {16'd0, half_v};
      default:   ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit top: request capture, memory req/ack handshake with an
// optional ack timeout, and the writeback response register.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_write,
  input  logic [2:0]  req_mode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  state_t      state;
  logic [31:0] cnt;
  logic [2:0]  cap_mode;
  logic [1:0]  cap_off;

  logic        legal;
  logic [3:0]  be;
  logic [31:0] lane_wdata;
  logic [31:0] ld_data;
  logic        timeout;

  lsu_align u_align (
    .is_write   (req_is_write),
    .mode       (req_mode),
    .off        (req_addr[1:0]),
    .wdata      (req_wdata),
    .legal      (legal),
    .be         (be),
    .lane_wdata (lane_wdata),
    .ld_mode    (cap_mode),
    .ld_off     (cap_off),
    .rdata      (mem_rdata),
    .ld_data    (ld_data)
  );

  // The count holds the number of ack-less BUS cycles already completed, so
  // the abort lands after exactly ACK_TIMEOUT cycles of mem_req.
  assign timeout = (ACK_TIMEOUT != 0) && ((cnt + 32'd1) == ACK_TIMEOUT);

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 32'd0;
      cap_mode  <= 3'd0;
      cap_off   <= 2'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_mode  <= req_mode;
            cap_off   <= req_addr[1:0];
            req_ready <= 1'b0;
            if (legal) begin
              state     <= BUS;
              cnt       <= 32'd0;
              mem_req   <= 1'b1;
              mem_we    <= req_is_write;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= be;
              mem_wdata <= req_is_write ? lane_wdata : 32'd0;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'd0;
            end
          end
        end
        BUS: begin
          if (mem_ack || timeout) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= !mem_ack;
            rsp_rdata <= (mem_ack && !mem_we) ? ld_data : 32'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for the load/store unit: table of transactions, a response
// scoreboard, and hand-written timeout, stall and reset sequences.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_write;
  logic [2:0]  req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        is_write;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          waits;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_mwdata;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[16];

  lsu #(.ACK_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_write (req_is_write),
    .req_mode     (req_mode),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every completed response handshake is checked against the
  // oldest expectation; a response with nothing expected is an error.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got err=%b rdata=%h expected no response", rsp_err, rsp_rdata);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        chk("rsp_rdata", rsp_rdata, e.rdata);
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_be"}, {28'd0, mem_be}, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic drive_req(input logic wr, input logic [2:0] mode,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_is_write = wr;
    req_mode     = mode;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  // One transaction: accept, memory phase with wait states, optional
  // writeback stall, then the response handshake.
  task automatic run_vec(input vec_t v, input int stall);
    exp_t e;
    wait_ready();
    e.err   = v.exp_err;
    e.rdata = v.exp_rdata;
    sb_q.push_back(e);
    drive_req(v.is_write, v.mode, v.addr, v.wdata);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (v.exp_err) begin
      chk("err_mem_req", {31'd0, mem_req}, 32'd0);
      chk("err_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    end else begin
      for (int w = 0; w <= v.waits; w++) begin
        chk("bus_mem_req", {31'd0, mem_req}, 32'd1);
        chk("bus_mem_we", {31'd0, mem_we}, {31'd0, v.is_write});
        chk("bus_mem_addr", mem_addr, {v.addr[31:2], 2'b00});
        chk("bus_mem_be", {28'd0, mem_be}, {28'd0, v.exp_be});
        chk("bus_mem_wdata", mem_wdata, v.exp_mwdata);
        chk("bus_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        if (w == v.waits) begin
          mem_ack   = 1'b1;
          mem_rdata = v.mrdata;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = ~v.mrdata;
        end
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0BAD_0BAD;
      end
      chk("done_mem_req", {31'd0, mem_req}, 32'd0);
      chk("done_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    end
    for (int s = 0; s < stall; s++) begin
      drive_req(1'b0, FUNCT3_BU, 32'h0000_0010, 32'd0);
      @(posedge clk); #1;
      chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_rsp_err", {31'd0, rsp_err}, {31'd0, v.exp_err});
      chk("stall_rsp_rdata", rsp_rdata, v.exp_rdata);
      chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
      chk("stall_mem_req", {31'd0, mem_req}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t sv;
    exp_t e;
    //          wr    mode       addr          wdata         mrdata        waits err  exp_rdata     be       mwdata
    vecs[0]  = '{1'b0, FUNCT3_B,  32'h103, 32'h0,         32'h112233F0, 0, 1'b0, 32'hFFFFFFF0, 4'b0001, 32'h0};
    vecs[1]  = '{1'b1, FUNCT3_H,  32'h102, 32'h0000BEEF,  32'h0,        3, 1'b0, 32'h0,        4'b0011, 32'hBEEFBEEF};
    vecs[2]  = '{1'b0, FUNCT3_HU, 32'h101, 32'h0,         32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0};
    vecs[3]  = '{1'b1, FUNCT3_BU, 32'h100, 32'h000000AA,  32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0};
    vecs[4]  = '{1'b0, 3'b111,    32'h100, 32'h0,         32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0};
    vecs[5]  = '{1'b0, FUNCT3_BU, 32'h100, 32'h0,         32'h80112233, 0, 1'b0, 32'h00000080, 4'b1000, 32'h0};
    vecs[6]  = '{1'b0, FUNCT3_H,  32'h100, 32'h0,         32'h80017FFF, 1, 1'b0, 32'hFFFF8001, 4'b1100, 32'h0};
    vecs[7]  = '{1'b0, FUNCT3_HU, 32'h102, 32'h0,         32'h12348765, 2, 1'b0, 32'h00008765, 4'b0011, 32'h0};
    vecs[8]  = '{1'b0, FUNCT3_W,  32'h204, 32'h0,         32'hDEADBEEF, 1, 1'b0, 32'hDEADBEEF, 4'b1111, 32'h0};
    vecs[9]  = '{1'b1, FUNCT3_W,  32'h208, 32'hCAFEF00D,  32'h0,        0, 1'b0, 32'h0,        4'b1111, 32'hCAFEF00D};
    vecs[10] = '{1'b1, FUNCT3_B,  32'h101, 32'h123456A5,  32'h0,        0, 1'b0, 32'h0,        4'b0100, 32'hA5A5A5A5};
    vecs[11] = '{1'b0, FUNCT3_W,  32'h202, 32'h0,         32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0};
    vecs[12] = '{1'b1, FUNCT3_H,  32'h103, 32'h00001234,  32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0};
    vecs[13] = '{1'b0, FUNCT3_B,  32'h102, 32'h0,         32'h00007F00, 0, 1'b0, 32'h0000007F, 4'b0010, 32'h0};
    vecs[14] = '{1'b1, 3'b011,    32'h100, 32'h0,         32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0};
    vecs[15] = '{1'b0, FUNCT3_W,  32'h200, 32'h0,         32'h01020304, 3, 1'b0, 32'h01020304, 4'b1111, 32'h0};

    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_is_write = 1'b0;
    req_mode     = 3'd0;
    req_addr     = 32'd0;
    req_wdata    = 32'd0;
    rsp_ready    = 1'b0;
    mem_ack      = 1'b0;
    mem_rdata    = 32'd0;

    // Reset values
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("post_reset");

    // Table of transactions
    for (int i = 0; i < 16; i++) run_vec(vecs[i], 0);

    // Ack timeout: mem_req holds for exactly four cycles, then an error
    wait_ready();
    e.err   = 1'b1;
    e.rdata = 32'd0;
    sb_q.push_back(e);
    drive_req(1'b0, FUNCT3_W, 32'h200, 32'd0);
    mem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("to_mem_req", {31'd0, mem_req}, 32'd1);
      chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    chk("to_mem_req_drop", {31'd0, mem_req}, 32'd0);
    chk("to_rsp_valid_set", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("to_post_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // Writeback stall for five cycles on a load
    sv = '{1'b0, FUNCT3_W, 32'h400, 32'h0, 32'h55AA00FF, 0, 1'b0, 32'h55AA00FF, 4'b1111, 32'h0};
    run_vec(sv, 5);

    // Reset in the middle of a bus access
    wait_ready();
    drive_req(1'b0, FUNCT3_W, 32'h300, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_bus_mem_req", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midbus_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("after_midbus_reset");
    sv = '{1'b0, FUNCT3_BU, 32'h0, 32'h0, 32'h9A000000, 0, 1'b0, 32'h0000009A, 4'b1000, 32'h0};
    run_vec(sv, 0);

    @(posedge clk); #1;
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
